// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud divisor, used by both tx and rx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: DIV clocks per bit, one-cycle bit_done on the last clock of each bit.
// restart holds the count at zero so the first bit is aligned to the edge that leaves restart.
module uart_baud_gen #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_done
);

  localparam int CNT_W = $clog2(DIV) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_done = !restart && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_axis_tx.sv
// AXI-Stream to UART serializer: tx registered, start bit 1 cycle after handshake; tready only in IDLE.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_axis_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 tx,
  output logic                 busy
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int BCNT_W   = $clog2(DATA_BITS + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_BITS - 1);

  uart_state_t          state, state_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt, shreg_shift;
  logic [BCNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic                 tx_q, tx_nxt;
  logic                 rdy_q, rdy_nxt;
  logic                 bit_done;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_nxt;
`endif

  uart_baud_gen #(.DIV(BAUD_DIV)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (state == IDLE),
    .bit_done (bit_done)
  );

  assign shreg_shift = shreg >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx_q    <= tx_nxt;
      rdy_q   <= rdy_nxt;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_nxt;
`endif
    end
  end

  // tx_nxt is the line level for the cycle after this edge, so tx needs no decode stage.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    tx_nxt      = tx_q;
    rdy_nxt     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt     = par_q;
`endif
    case (state)
      IDLE: begin
        tx_nxt  = 1'b1;
        rdy_nxt = 1'b1;
        if (s_axis_tvalid && rdy_q) begin
          state_nxt = START;
          shreg_nxt = s_axis_tdata;
          tx_nxt    = 1'b0;
          rdy_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_nxt   = ^s_axis_tdata;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
          tx_nxt      = shreg[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          shreg_nxt = shreg_shift;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
            tx_nxt    = par_q;
`else
            state_nxt = STOP;
            tx_nxt    = 1'b1;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            tx_nxt      = shreg_shift[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_nxt = IDLE;
          rdy_nxt   = 1'b1;
          tx_nxt    = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  assign s_axis_tready = rdy_q;
  assign tx            = tx_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_uart_axis_tx.sv
// Bench for uart_axis_tx at CLK_FREQ=160, BAUD=10 (16 clocks per bit).
// A frame-level model predicts tx/tready/busy every cycle; a bench receiver decodes tx back to bytes.
module tb_uart_axis_tx;

  localparam int DATA_BITS = 8;
  localparam int DIV       = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB  = DATA_BITS + 3;
  localparam int GAP = 177;
`else
  localparam int NB  = DATA_BITS + 2;
  localparam int GAP = 161;
`endif
  localparam int FRAME = NB * DIV;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [DATA_BITS-1:0] s_axis_tdata = '0;
  logic                 s_axis_tvalid = 1'b0;
  logic                 s_axis_tready;
  logic                 tx;
  logic                 busy;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  uart_axis_tx #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(DATA_BITS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .tx            (tx),
    .busy          (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: bound expired, required event not seen (t=%0t)", name, $time);
  endtask

  // Frame as a list of line levels, one entry per bit period.
  function automatic logic [NB-1:0] make_frame(input logic [DATA_BITS-1:0] d);
    logic [NB-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[DATA_BITS+1] = ^d;
`endif
    return f;
  endfunction

  int                    m_pos;
  bit                    m_rdy;
  logic [NB-1:0]         m_frame;
  logic [DATA_BITS-1:0]  exp_q[$];

  // m_pos = cycle number within the frame (1..FRAME), 0 when idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= 0;
      m_rdy <= 1'b0;
      exp_q.delete();
    end else if (m_pos != 0) begin
      if (m_pos == FRAME) begin
        m_pos <= 0;
        m_rdy <= 1'b1;
      end else begin
        m_pos <= m_pos + 1;
      end
    end else if (m_rdy && s_axis_tvalid) begin
      m_frame <= make_frame(s_axis_tdata);
      m_pos   <= 1;
      m_rdy   <= 1'b0;
      exp_q.push_back(s_axis_tdata);
    end else begin
      m_rdy <= 1'b1;
    end
  end

  bit   chk_en = 1'b0;
  logic exp_tx;
  always_comb begin
    exp_tx = 1'b1;
    if (m_pos != 0) exp_tx = m_frame[(m_pos - 1) / DIV];
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx", tx, exp_tx);
      check("tready", s_axis_tready, m_rdy);
      check("busy", busy, m_pos != 0);
    end
  end

  int                   rx_cnt = 0;
  int                   rx_frames = 0;
  logic [DATA_BITS-1:0] rx_byte = '0;
  logic [DATA_BITS-1:0] rx_last = '0;

  // rx_cnt equals the frame cycle number of the current negedge sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_cnt <= 0;
    end else if (rx_cnt == 0) begin
      if (tx === 1'b0) rx_cnt <= 2;
    end else begin
      rx_cnt <= (rx_cnt == FRAME) ? 0 : rx_cnt + 1;
      if (rx_cnt >= 24 && (rx_cnt - 24) % DIV == 0 && (rx_cnt - 24) / DIV < DATA_BITS)
        rx_byte[(rx_cnt - 24) / DIV] <= tx;
      if (rx_cnt == 24 + DIV * (DATA_BITS - 1) + 1) begin
        rx_last   <= rx_byte;
        rx_frames <= rx_frames + 1;
        if (exp_q.size() == 0) fail("rx frame with no handshake");
        else check("rx byte", rx_byte, exp_q.pop_front());
      end
      if (rx_cnt == FRAME - DIV / 2) check("rx stop bit", tx, 1'b1);
    end
  end

  logic cap_tx  [1:FRAME+16];
  logic cap_rdy [1:FRAME+16];
  int   a5_seq  [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  task automatic capture();
    for (int k = 1; k <= FRAME + 16; k++) begin
      @(negedge clk);
      cap_tx[k]  = tx;
      cap_rdy[k] = s_axis_tready;
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_rdy) return;
      @(posedge clk);
      #1;
    end
    fail("wait_ready");
  endtask

  task automatic send(input logic [DATA_BITS-1:0] d);
    wait_ready();
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  int   fall1, fall2, n0;
  logic prev;

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1'b1);
    check("reset tready", s_axis_tready, 1'b0);
    check("reset busy", busy, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("tready before first edge", s_axis_tready, 1'b0);
    @(posedge clk);
    #1 check("tready after first edge", s_axis_tready, 1'b1);

    // 0xA5 single frame
    send(8'hA5);
    capture();
    check("A5 start first cycle", cap_tx[1], 1'b0);
    check("A5 start last cycle", cap_tx[DIV], 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("A5 data bit first cycle", cap_tx[17 + 16 * i], a5_seq[i]);
      check("A5 data bit last cycle", cap_tx[32 + 16 * i], a5_seq[i]);
    end
`ifdef UART_TX_PARITY_EN
    check("A5 parity", cap_tx[145], 1'b0);
`endif
    check("A5 stop last cycle", cap_tx[FRAME], 1'b1);
    check("A5 tready in last stop cycle", cap_rdy[FRAME], 1'b0);
    check("A5 tready after frame", cap_rdy[FRAME + 1], 1'b1);

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    capture();
    check("07 data bit7", cap_tx[144], 1'b0);
    check("07 parity first", cap_tx[145], 1'b1);
    check("07 parity last", cap_tx[160], 1'b1);
    check("07 stop", cap_tx[161], 1'b1);
    check("07 tready at 176", cap_rdy[176], 1'b0);
    check("07 tready at 177", cap_rdy[177], 1'b1);
`endif

    // back-to-back 0x00 then 0xFF with tvalid held
    wait_ready();
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1 s_axis_tdata = 8'hFF;
    fall1 = 0;
    fall2 = 0;
    prev  = 1'b1;
    for (int k = 1; k <= 2 * FRAME + 4 && fall2 == 0; k++) begin
      @(negedge clk);
      if (prev === 1'b1 && tx === 1'b0) begin
        if (fall1 == 0) fall1 = k;
        else fall2 = k;
      end
      prev = tx;
      if (fall2 != 0) s_axis_tvalid = 1'b0;
    end
    s_axis_tvalid = 1'b0;
    check("b2b first start cycle", fall1, 1);
    check("b2b start spacing", fall2 - fall1, GAP);

    // tvalid pulse and tdata churn mid-frame
    wait_ready();
    n0 = rx_frames;
    send(8'h3C);
    s_axis_tdata = 8'h81;
    repeat (30) @(posedge clk);
    #1 s_axis_tvalid = 1'b1;
    s_axis_tdata = 8'h7E;
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
    s_axis_tdata = 8'h55;
    wait_ready();
    repeat (2) @(posedge clk);
    #1;
    check("mid-frame ignore byte", rx_last, 8'h3C);
    check("mid-frame ignore count", rx_frames - n0, 1);

    // reset at cycle 70 of a frame (data bit 3 of 0x52 is 0)
    send(8'h52);
    repeat (69) @(posedge clk);
    #1 check("pre-reset tx low", tx, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid reset tx", tx, 1'b1);
    check("mid reset tready", s_axis_tready, 1'b0);
    check("mid reset busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    check("held reset tx", tx, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("release tready before edge", s_axis_tready, 1'b0);
    @(posedge clk);
    #1 check("release tready after edge", s_axis_tready, 1'b1);
    n0 = rx_frames;
    repeat (FRAME) @(posedge clk);
    #1 check("no residual frame", rx_frames - n0, 0);

    // loopback: 256 random bytes, tvalid held, tdata scrambled mid-frame
    n0 = rx_frames;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 256; n++) begin
      wait_ready();
      s_axis_tdata = DATA_BITS'($urandom);
      @(posedge clk);
      #1 s_axis_tdata = DATA_BITS'($urandom);
    end
    s_axis_tvalid = 1'b0;
    wait_ready();
    repeat (4) @(posedge clk);
    #1;
    check("loopback frame count", rx_frames - n0, 256);
    check("loopback queue drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
